// File: rtl/wb_initiator_seq.sv
// Wishbone B4 classic initiator: one bus cycle per valid/ready command, result on a valid/ready response port.
// Optional WBM_ERR_INPUT_EN adds a wbm_err_i slave error input (priority ack > err > timeout).
module wb_initiator_seq #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 16
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_ni,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_we_i,
  input  logic [AW-1:0]     req_adr_i,
  input  logic [DW-1:0]     req_dat_i,
  input  logic [DW/8-1:0]   req_sel_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [DW-1:0]     rsp_dat_o,
  output logic              rsp_err_o,
  output logic              wbm_cyc_o,
  output logic              wbm_stb_o,
  output logic              wbm_we_o,
  output logic [DW/8-1:0]   wbm_sel_o,
  output logic [AW-1:0]     wbm_adr_o,
  output logic [DW-1:0]     wbm_dat_o,
  input  logic [DW-1:0]     wbm_dat_i,
  input  logic              wbm_ack_i,
`ifdef WBM_ERR_INPUT_EN
  input  logic              wbm_err_i,
`endif
  output logic              busy_o,
  output logic [CNT_W-1:0]  txn_cnt_o,
  output logic [CNT_W-1:0]  err_cnt_o
);

  // Timeout counter only needs to reach TIMEOUT-1.
  localparam int TW       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int TMO_LAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

  typedef enum logic [1:0] {IDLE, BUS, RESP} state_e;

  state_e             state_q, state_d;
  logic               cyc_q, cyc_d;
  logic               we_q, we_d;
  logic [AW-1:0]      adr_q, adr_d;
  logic [DW-1:0]      dat_q, dat_d;
  logic [DW/8-1:0]    sel_q, sel_d;
  logic [DW-1:0]      rsp_dat_q, rsp_dat_d;
  logic               rsp_err_q, rsp_err_d;
  logic [TW-1:0]      tmo_q, tmo_d;
  logic [CNT_W-1:0]   txn_q, txn_d;
  logic [CNT_W-1:0]   err_q, err_d;
  logic               bus_err;
  logic               tmo_hit;

`ifdef WBM_ERR_INPUT_EN
  assign bus_err = wbm_err_i;
`else
  assign bus_err = 1'b0;
`endif

  assign tmo_hit = (TIMEOUT != 0) && (tmo_q == TW'(TMO_LAST));

  always_comb begin
    state_d   = state_q;
    cyc_d     = cyc_q;
    we_d      = we_q;
    adr_d     = adr_q;
    dat_d     = dat_q;
    sel_d     = sel_q;
    rsp_dat_d = rsp_dat_q;
    rsp_err_d = rsp_err_q;
    tmo_d     = tmo_q;
    txn_d     = txn_q;
    err_d     = err_q;
    unique case (state_q)
      IDLE: begin
        if (req_valid_i) begin
          cyc_d   = 1'b1;
          we_d    = req_we_i;
          adr_d   = req_adr_i;
          dat_d   = req_dat_i;
          sel_d   = req_sel_i;
          tmo_d   = '0;
          state_d = BUS;
        end
      end
      BUS: begin
        if (wbm_ack_i) begin
          cyc_d     = 1'b0;
          we_d      = 1'b0;
          rsp_dat_d = we_q ? '0 : wbm_dat_i;
          rsp_err_d = 1'b0;
          txn_d     = txn_q + CNT_W'(1);
          state_d   = RESP;
        end else if (bus_err || tmo_hit) begin
          cyc_d     = 1'b0;
          we_d      = 1'b0;
          rsp_dat_d = '0;
          rsp_err_d = 1'b1;
          txn_d     = txn_q + CNT_W'(1);
          err_d     = err_q + CNT_W'(1);
          state_d   = RESP;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      RESP: begin
        if (rsp_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_q   <= IDLE;
      cyc_q     <= 1'b0;
      we_q      <= 1'b0;
      adr_q     <= '0;
      dat_q     <= '0;
      sel_q     <= '0;
      rsp_dat_q <= '0;
      rsp_err_q <= 1'b0;
      tmo_q     <= '0;
      txn_q     <= '0;
      err_q     <= '0;
    end else begin
      state_q   <= state_d;
      cyc_q     <= cyc_d;
      we_q      <= we_d;
      adr_q     <= adr_d;
      dat_q     <= dat_d;
      sel_q     <= sel_d;
      rsp_dat_q <= rsp_dat_d;
      rsp_err_q <= rsp_err_d;
      tmo_q     <= tmo_d;
      txn_q     <= txn_d;
      err_q     <= err_d;
    end
  end

  assign req_ready_o = (state_q == IDLE) && wb_rst_ni;
  assign rsp_valid_o = (state_q == RESP);
  assign busy_o      = (state_q != IDLE);
  assign rsp_dat_o   = rsp_dat_q;
  assign rsp_err_o   = rsp_err_q;
  assign wbm_cyc_o   = cyc_q;
  assign wbm_stb_o   = cyc_q;
  assign wbm_we_o    = we_q;
  assign wbm_adr_o   = adr_q;
  assign wbm_dat_o   = dat_q;
  assign wbm_sel_o   = sel_q;
  assign txn_cnt_o   = txn_q;
  assign err_cnt_o   = err_q;

endmodule

// File: tb/tb_wb_initiator_seq.sv
// Directed bench for wb_initiator_seq with TIMEOUT=4; inputs change and outputs are sampled on the falling edge.
module tb_wb_initiator_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_we;
  logic [31:0] req_adr, req_dat;
  logic [3:0]  req_sel;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_dat;
  logic        cyc, stb, we;
  logic [3:0]  sel;
  logic [31:0] adr, dat_o, dat_i;
  logic        ack;
  logic        busy;
  logic [15:0] txn_cnt, err_cnt;
`ifdef WBM_ERR_INPUT_EN
  logic        werr;
`endif

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  wb_initiator_seq #(.AW(32), .DW(32), .TIMEOUT(4), .CNT_W(16)) dut (
    .wb_clk_i(clk), .wb_rst_ni(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_we_i(req_we),
    .req_adr_i(req_adr), .req_dat_i(req_dat), .req_sel_i(req_sel),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_dat_o(rsp_dat), .rsp_err_o(rsp_err),
    .wbm_cyc_o(cyc), .wbm_stb_o(stb), .wbm_we_o(we), .wbm_sel_o(sel),
    .wbm_adr_o(adr), .wbm_dat_o(dat_o), .wbm_dat_i(dat_i), .wbm_ack_i(ack),
`ifdef WBM_ERR_INPUT_EN
    .wbm_err_i(werr),
`endif
    .busy_o(busy), .txn_cnt_o(txn_cnt), .err_cnt_o(err_cnt)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    else n_pass++;
  endtask

  // Presents a request at the current falling edge; returns at the falling edge of the first BUS cycle.
  task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    req_valid = 1'b1; req_we = w; req_adr = a; req_dat = d; req_sel = s;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic consume();
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  initial begin
    int n;
    logic [31:0] held;
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_adr = '0; req_dat = '0; req_sel = '0;
    rsp_ready = 1'b0; dat_i = '0; ack = 1'b0;
`ifdef WBM_ERR_INPUT_EN
    werr = 1'b0;
`endif
    #1;
    check("rst_cyc", cyc, 0);
    check("rst_stb", stb, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_req_ready", req_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_txn", txn_cnt, 0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_req_ready", req_ready, 1);

    // Write, slave acks after two wait cycles.
    issue(1'b1, 32'h3000_0004, 32'hA5A5_1234, 4'hF);
    for (int i = 0; i < 3; i++) begin
      check("wr_cyc", cyc, 1);
      check("wr_stb", stb, 1);
      check("wr_we", we, 1);
      check("wr_adr", adr, 32'h3000_0004);
      check("wr_dat", dat_o, 32'hA5A5_1234);
      check("wr_sel", sel, 4'hF);
      if (i == 2) ack = 1'b1;
      @(negedge clk);
    end
    ack = 1'b0;
    check("wr_cyc_done", cyc, 0);
    check("wr_rsp_valid", rsp_valid, 1);
    check("wr_rsp_err", rsp_err, 0);
    check("wr_rsp_dat", rsp_dat, 0);
    check("wr_txn", txn_cnt, 1);
    consume();
    check("wr_idle", busy, 0);

    // Read, zero-wait slave, 3-cycle turnaround with rsp_ready held.
    issue(1'b0, 32'h3000_0010, 32'h0, 4'hF);
    check("rd_cyc", cyc, 1);
    check("rd_we", we, 0);
    ack = 1'b1; dat_i = 32'hCAFE_F00D; rsp_ready = 1'b1;
    @(negedge clk);
    ack = 1'b0; dat_i = '0;
    check("rd_rsp_valid", rsp_valid, 1);
    check("rd_rsp_dat", rsp_dat, 32'hCAFE_F00D);
    check("rd_rsp_err", rsp_err, 0);
    check("rd_cyc_done", cyc, 0);
    check("rd_txn", txn_cnt, 2);
    @(negedge clk);
    rsp_ready = 1'b0;
    check("rd_ready_again", req_ready, 1);
    check("rd_adr_kept", adr, 32'h3000_0010);

    // Timeout: no ack, cycle must last exactly 4 cycles.
    dat_i = 32'hDEAD_BEEF;
    issue(1'b0, 32'h3000_0020, 32'h0, 4'h3);
    n = 0;
    while (cyc && n < 20) begin n++; @(negedge clk); end
    check("tmo_len", n, 4);
    check("tmo_rsp_valid", rsp_valid, 1);
    check("tmo_rsp_err", rsp_err, 1);
    check("tmo_rsp_dat", rsp_dat, 0);
    check("tmo_err_cnt", err_cnt, 1);
    check("tmo_txn", txn_cnt, 3);
    consume();

    // Ack in the last allowed cycle beats the timeout.
    issue(1'b0, 32'h3000_0024, 32'h0, 4'hF);
    @(negedge clk); @(negedge clk); @(negedge clk);
    check("tmo4_cyc", cyc, 1);
    ack = 1'b1; dat_i = 32'h1234_5678;
    @(negedge clk);
    ack = 1'b0;
    check("tmo4_rsp_err", rsp_err, 0);
    check("tmo4_rsp_dat", rsp_dat, 32'h1234_5678);
    check("tmo4_err_cnt", err_cnt, 1);
    check("tmo4_txn", txn_cnt, 4);
    consume();

    // Response backpressure with a second request waiting.
    issue(1'b0, 32'h3000_0030, 32'h0, 4'hF);
    ack = 1'b1; dat_i = 32'h0BAD_CAFE;
    @(negedge clk);
    ack = 1'b0; dat_i = '0;
    req_valid = 1'b1; req_we = 1'b1; req_adr = 32'h3000_0040; req_dat = 32'h5555_AAAA; req_sel = 4'h1;
    held = rsp_dat;
    check("bp_rsp_dat", held, 32'h0BAD_CAFE);
    for (int i = 0; i < 5; i++) begin
      check("bp_req_ready", req_ready, 0);
      check("bp_rsp_valid", rsp_valid, 1);
      check("bp_rsp_stable", rsp_dat, held);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check("bp_ready_after", req_ready, 1);
    check("bp_rsp_dropped", rsp_valid, 0);
    check("bp_not_yet", cyc, 0);
    @(negedge clk);
    req_valid = 1'b0;
    check("bp2_cyc", cyc, 1);
    check("bp2_adr", adr, 32'h3000_0040);
    check("bp2_we", we, 1);
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    check("bp2_txn", txn_cnt, 6);
    consume();

    // Asynchronous reset in the middle of a bus cycle.
    issue(1'b0, 32'h3000_0050, 32'h0, 4'hF);
    check("mid_cyc", cyc, 1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_cyc", cyc, 0);
    check("mid_rst_stb", stb, 0);
    check("mid_rst_rsp_valid", rsp_valid, 0);
    check("mid_rst_txn", txn_cnt, 0);
    check("mid_rst_err_cnt", err_cnt, 0);
    @(negedge clk);
    rst_n = 1'b1;
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    @(negedge clk);
    check("stray_ack_rsp", rsp_valid, 0);
    check("stray_ack_busy", busy, 0);

`ifdef WBM_ERR_INPUT_EN
    // Slave error on the second bus cycle.
    dat_i = 32'h7777_7777;
    issue(1'b0, 32'h3000_0060, 32'h0, 4'hF);
    @(negedge clk);
    werr = 1'b1;
    @(negedge clk);
    werr = 1'b0;
    check("err_rsp_err", rsp_err, 1);
    check("err_rsp_dat", rsp_dat, 0);
    check("err_err_cnt", err_cnt, 1);
    consume();
    // Ack and err together: ack wins.
    issue(1'b0, 32'h3000_0064, 32'h0, 4'hF);
    ack = 1'b1; werr = 1'b1;
    @(negedge clk);
    ack = 1'b0; werr = 1'b0;
    check("ackerr_rsp_err", rsp_err, 0);
    check("ackerr_rsp_dat", rsp_dat, 32'h7777_7777);
    check("ackerr_err_cnt", err_cnt, 1);
    consume();
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/wb_initiator_seq.md
Name: wb_initiator_seq

Overview:
- Wishbone classic (B4, non-pipelined) initiator.
- Converts single requests on a valid/ready command port into one Wishbone read or write cycle each, then returns the result on a valid/ready response port.
- Sits inside user_proj_top, so on-chip logic (LA-driven test sequencer, core debug port) can master the internal Wishbone fabric the management SoC otherwise drives.
- Includes bus timeout protection plus transaction and error counters.

Parameters:
AW, 32, address width
DW, 32, data width; sel width is DW/8
TIMEOUT, 255, max BUS cycles without ack before abort; 0 disables timeout
CNT_W, 16, width of the statistics counters

Ports:
wb_clk_i  in  1  clock, all logic rising-edge
wb_rst_ni  in  1  asynchronous active-low reset
req_valid_i  in  1  command valid
req_ready_o  out  1  command accepted when valid&ready
req_we_i  in  1  1=write, 0=read
req_adr_i  in  AW  target address
req_dat_i  in  DW  write data
req_sel_i  in  DW/8  byte selects
rsp_valid_o  out  1  response valid
rsp_ready_i  in  1  response consumed when valid&ready
rsp_dat_o  out  DW  read data (0 for writes and errors)
rsp_err_o  out  1  1=timeout or bus error
wbm_cyc_o  out  1  Wishbone cycle
wbm_stb_o  out  1  Wishbone strobe
wbm_we_o  out  1  Wishbone write enable
wbm_sel_o  out  DW/8  Wishbone byte selects
wbm_adr_o  out  AW  Wishbone address
wbm_dat_o  out  DW  Wishbone write data
wbm_dat_i  in  DW  Wishbone read data
wbm_ack_i  in  1  Wishbone acknowledge
busy_o  out  1  state != IDLE
txn_cnt_o  out  CNT_W  completed transactions (ack or error), wraps
err_cnt_o  out  CNT_W  errored transactions, wraps

Behaviour:
- Reset (async assert, sync release): state IDLE; all wbm_* outputs 0; rsp_valid_o=0, rsp_dat_o=0, rsp_err_o=0; counters 0; busy_o=0.
- req_ready_o = (state==IDLE) and reset released; combinational, 0 while wb_rst_ni=0.
- IDLE:
  - On req_valid_i&req_ready_o, register we/adr/dat/sel onto wbm_* outputs and set cyc=stb=1 at the same edge → BUS.
  - Cycle N accept → cyc/stb high in cycle N+1.
- BUS:
  - wbm_* held stable.
  - Timeout counter cleared on entry, +1 each cycle without ack.
  - wbm_ack_i=1: cyc/stb/we→0 at that edge; rsp_dat_o=wbm_dat_i for reads, 0 for writes; rsp_err_o=0 → RESP.
  - Counter==TIMEOUT-1 and no ack (TIMEOUT≠0): cyc/stb/we→0; rsp_dat_o=0; rsp_err_o=1 → RESP.
  - Ack and timeout in the same cycle: ack wins.
  - Zero-wait-state slave: ack in first BUS cycle → one-cycle bus phase.
- RESP:
  - rsp_valid_o=1; rsp_dat/err held.
  - On rsp_ready_i → IDLE, rsp_valid_o→0.
  - txn_cnt_o +1 on entry to RESP; err_cnt_o +1 when entering with err.
  - Counters wrap all-ones→0.
- wbm_ack_i outside BUS is ignored; no state change.
- Minimum throughput: 3 cycles per transaction (accept, BUS, RESP with rsp_ready_i=1). No new request is accepted until the response is consumed.
- wbm_adr_o/dat_o/sel_o keep their last values after a cycle ends; only cyc/stb/we return to 0.
- Reset mid-BUS: cyc/stb drop immediately (async); the pending transaction is lost and no response is issued.

Optional Feature:
- Macro WBM_ERR_INPUT_EN.
- Defined:
  - Adds input port wbm_err_i (1 bit).
  - In BUS, wbm_err_i=1 terminates the cycle like ack but with rsp_err_o=1, rsp_dat_o=0, and err_cnt_o increments.
  - Priority: ack > err > timeout.
- Undefined: port absent; only timeout produces errors.

Test Plan:
- Write: req we=1 adr=0x3000_0004 dat=0xA5A5_1234 sel=0xF; slave acks after 2 wait cycles → wbm_* match for 3 cycles, cyc low after ack; rsp_valid=1, err=0, dat=0; txn_cnt=1.
- Read: we=0 adr=0x3000_0010; slave acks first cycle with 0xCAFE_F00D → rsp_dat=0xCAFE_F00D, err=0, 3-cycle total with rsp_ready=1.
- Timeout, TIMEOUT=4, no ack → cyc high exactly 4 cycles, then rsp_err=1, dat=0; err_cnt=1. Repeat with ack in the 4th cycle → err=0.
- Backpressure: rsp_ready=0 for 5 cycles after read completes, req_valid held with a second request → req_ready=0 throughout, rsp held stable; second request accepted the cycle after rsp_ready=1.
- Reset mid-BUS: assert wb_rst_ni=0 while cyc=1 → cyc/stb/rsp_valid 0 without a clock edge; counters 0; after release, stray ack produces no response.
- WBM_ERR_INPUT_EN: read with wbm_err_i=1 on 2nd BUS cycle → rsp_err=1, err_cnt=1; ack and err asserted together → err=0.
